// File: rtl/aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes128_round_ctrl
// Brief    : Iterative AES-128 encryption controller, one round per clock,
//            valid/ready handshakes on both the plaintext and ciphertext side.
// Revision : 1.0 - initial release
// ============================================================================
module aes128_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_o
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_round_ctrl: NR must be 10 (AES-128 only)");
    end

    localparam logic [3:0] c_nr   = 4'(NR);
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [7:0] c_sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_nxt;
    logic [127:0] r_blk;
    logic [127:0] r_key;
    logic [127:0] r_out_data;
    logic [3:0]   r_round;
    logic         r_out_valid;

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_rk;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_rcon;
    logic         w_last;

    // Round datapath: SubBytes -> ShiftRows -> MixColumns on the held state.
    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign w_sb[8*i +: 8] = c_sbox[r_blk[8*i +: 8]];
    end

    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            assign w_sr[8*(4*c+r) +: 8] = w_sb[8*(4*((c+r)%4)+r) +: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mc
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[32*c      +: 8];
        assign w_a1 = w_sr[32*c + 8  +: 8];
        assign w_a2 = w_sr[32*c + 16 +: 8];
        assign w_a3 = w_sr[32*c + 24 +: 8];
        assign w_mc[32*c      +: 8] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[32*c + 8  +: 8] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[32*c + 16 +: 8] = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
        assign w_mc[32*c + 24 +: 8] = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
    end

    // On-the-fly key schedule: next round key derived from the current one.
    assign w_rot = {r_key[103:96], r_key[127:104]};
    for (genvar i = 0; i < 4; i++) begin : g_ks
        assign w_sub[8*i +: 8] = c_sbox[w_rot[8*i +: 8]];
    end
    assign w_t  = w_sub ^ {24'h0, w_rcon};
    assign w_n0 = r_key[31:0]   ^ w_t;
    assign w_n1 = r_key[63:32]  ^ w_n0;
    assign w_n2 = r_key[95:64]  ^ w_n1;
    assign w_n3 = r_key[127:96] ^ w_n2;
    assign w_rk = {w_n3, w_n2, w_n1, w_n0};

    always_comb begin
        w_rcon = 8'h00;
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_last = (r_round == c_nr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= c_idle;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            c_idle:  if (in_valid) w_fsm_nxt = c_run;
            c_run:   if (w_last) w_fsm_nxt = c_done;
            c_done:  if (out_ready) w_fsm_nxt = c_idle;
            default: w_fsm_nxt = c_idle;
        endcase
    end

    always_comb begin
        in_ready = (r_fsm == c_idle);
        busy     = (r_fsm == c_run) || (r_fsm == c_done);
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign round_o   = r_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk       <= '0;
            r_key       <= '0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_fsm)
                c_idle: begin
                    if (in_valid) begin
                        r_blk   <= in_data ^ in_key;
                        r_key   <= in_key;
                        r_round <= 4'd1;
                    end
                end
                c_run: begin
                    r_blk   <= (w_last ? w_sr : w_mc) ^ w_rk;
                    r_key   <= w_rk;
                    r_round <= r_round + 4'd1;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sr ^ w_rk;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_round     <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_round_ctrl
// Brief    : Self-checking bench for aes128_round_ctrl: known-answer table,
//            handshake corner sequences and random blocks vs a GF(2^8) model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes128_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_o;

    always #5 clk = ~clk;

    aes128_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_o   (round_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] tb_sbox [256];

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs [3];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box built from the field inverse plus the affine map, not a table.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] w [44][4];
        logic [7:0] st [4][4];
        logic [7:0] tmp [4][4];
        logic [7:0] t [4];
        logic [7:0] rc = 8'h01;
        logic [127:0] res = '0;
        for (int j = 0; j < 4; j++)
            for (int r = 0; r < 4; r++) w[j][r] = key[8*(4*j+r) +: 8];
        for (int j = 4; j < 44; j++) begin
            for (int r = 0; r < 4; r++) t[r] = w[j-1][r];
            if (j % 4 == 0) begin
                for (int r = 0; r < 4; r++) t[r] = tb_sbox[w[j-1][(r+1)%4]];
                t[0] = t[0] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            for (int r = 0; r < 4; r++) w[j][r] = w[j-4][r] ^ t[r];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = pt[8*(4*c+r) +: 8] ^ w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r][c] = tb_sbox[st[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c])
                                 ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
                    else
                        st[r][c] = tmp[r][c];
                    st[r][c] = st[r][c] ^ w[4*rnd+c][r];
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[8*(4*c+r) +: 8] = st[r][c];
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One full transaction; optional round tracing, an in_valid poke during
    // RUN, and a number of back-pressured cycles before the ciphertext is taken.
    task automatic do_block(input logic [127:0] key, input logic [127:0] pt,
                            input bit chk_rounds, input int poke_at, input int hold,
                            output logic [127:0] ct);
        int edges;
        in_key    = key;
        in_data   = pt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("accept in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_key   = rnd128();
        in_data  = rnd128();
        edges    = 0;
        while (!out_valid && edges < 30) begin
            if (chk_rounds) chk("round_o run", round_o, edges + 1);
            if (edges == poke_at) begin
                in_valid = 1'b1;
                in_data  = rnd128();
            end else begin
                in_valid = 1'b0;
            end
            step();
            edges++;
        end
        in_valid = 1'b0;
        chk("latency", edges, 10);
        chk("round_o done", round_o, 11);
        chk("busy done", busy, 1);
        ct = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = rnd128();
            chk("hold out_valid", out_valid, 1);
            chk("hold in_ready", in_ready, 0);
            chk("hold out_data", out_data, ct);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release out_valid", out_valid, 0);
        chk("release in_ready", in_ready, 1);
        chk("release round_o", round_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, k2, p2;
        logic [127:0] got [2];
        int acc_cyc [2];
        int accepts, outs;
        bit acc;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = affine(inv);
        end

        vecs[0] = '{"fips_c1",
                    128'h0f0e0d0c0b0a09080706050403020100,
                    128'hffeeddccbbaa99887766554433221100,
                    128'h5ac5b47080b7cdd830047b6ad8e0c469};
        vecs[1] = '{"zero", 128'h0, 128'h0, 128'h2e2b34ca59fa4c883b2c8aefd44be966};
        vecs[2] = '{"fips_b",
                    128'h3c4fcf098815f7aba6d2ae2816157e2b,
                    128'h340737e0a29831318d305a88a8f64332,
                    128'h320b6a19978511dcfb09dc021d842539};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        step();
        step();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset busy", busy, 0);
        chk("reset round_o", round_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            do_block(vecs[i].key, vecs[i].pt, (i == 0), -1, 0, ct);
            chk(vecs[i].name, ct, vecs[i].ct);
        end

        do_block(vecs[0].key, vecs[0].pt, 1'b0, -1, 20, ct);
        chk("backpressure ct", ct, vecs[0].ct);

        do_block(vecs[0].key, vecs[0].pt, 1'b0, 3, 0, ct);
        chk("poke during run ct", ct, vecs[0].ct);

        // Reset while computing round 5; a second reset edge overlaps in_valid in IDLE.
        in_key = vecs[0].key; in_data = vecs[0].pt; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre-reset round_o", round_o, 5);
        rst = 1'b1; in_valid = 1'b1;
        step();
        chk("mid-run rst in_ready", in_ready, 1);
        chk("mid-run rst out_valid", out_valid, 0);
        chk("mid-run rst round_o", round_o, 0);
        chk("mid-run rst out_data", out_data, 0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst vs in_valid round_o", round_o, 0);
        chk("rst vs in_valid busy", busy, 0);
        do_block(vecs[0].key, vecs[0].pt, 1'b0, -1, 0, ct);
        chk("after reset ct", ct, vecs[0].ct);

        for (int n = 0; n < 8; n++) begin
            k2 = rnd128();
            p2 = rnd128();
            do_block(k2, p2, 1'b0, -1, int'($urandom_range(0, 3)), ct);
            chk("random ct", ct, aes_ref(k2, p2));
        end

        // Back-to-back issue with the sink always ready.
        k2 = rnd128(); p2 = rnd128();
        accepts = 0; outs = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; got[0] = '0; got[1] = '0;
        in_key = vecs[0].key; in_data = vecs[0].pt; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = in_valid && in_ready;
            if (out_valid && outs < 2) begin
                got[outs] = out_data;
                outs++;
            end
            step();
            if (acc && accepts < 2) begin
                acc_cyc[accepts] = cyc;
                accepts++;
                if (accepts == 1) begin
                    in_key = k2; in_data = p2;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        chk("b2b accepts", accepts, 2);
        chk("b2b issue interval", acc_cyc[1] - acc_cyc[0], 12);
        chk("b2b outputs", outs, 2);
        chk("b2b ct0", got[0], vecs[0].ct);
        chk("b2b ct1", got[1], aes_ref(k2, p2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
